demux_1a2: RTL and testbench

- Receive-side counterpart of the 2:1 byte mux: splits one 8-bit valid-qualified stream back into two lanes at clk_2f.
- Consecutive valid bytes alternate lane 0 / lane 1, starting at lane 0.
- Optional realignment on a sync byte forces it onto lane 0.
- Optional idle timeout returns the selector to lane 0 after a long gap.

---
 rtl/demux_1a2.sv | 134 +++++++++++++
 tb/tb_demux_1a2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1a2.sv
`default_nettype none
// ============================================================================
// Module   : demux_1a2
// Purpose  : Receive-side 1:2 byte demultiplexer. Splits one valid-qualified
//            8-bit stream into two lanes, alternating lane 0 / lane 1 on
//            consecutive valid bytes and starting on lane 0. A sync byte can
//            force realignment onto lane 0, and an optional idle timeout
//            returns the selector to lane 0 after a long gap.
// Ports    : clk_2f         - single clock, rising edge
//            reset          - asynchronous active-low reset
//            data_in_c      - serialized byte stream
//            valid_in_c     - data_in_c qualifier
//            data_out_0_c   - lane 0 byte (0 when lane 0 not valid)
//            valid_out_0_c  - lane 0 qualifier
//            data_out_1_c   - lane 1 byte (0 when lane 1 not valid)
//            valid_out_1_c  - lane 1 qualifier
//            realign_c      - pulse: sync byte arrived while lane 1 was next
// Revision : 1.0 - initial release
// ============================================================================
module demux_1a2 #(
   parameter logic [7:0] SYNC_BYTE   = 8'hBC,
   parameter bit         ALIGN_EN    = 1'b1,
   parameter int         IDLE_CYCLES = 0
) (
   input  logic       clk_2f,
   input  logic       reset,
   input  logic [7:0] data_in_c,
   input  logic       valid_in_c,
   output logic [7:0] data_out_0_c,
   output logic       valid_out_0_c,
   output logic [7:0] data_out_1_c,
   output logic       valid_out_1_c,
   output logic       realign_c
);

   localparam logic [7:0] c_idle_lim = 8'(IDLE_CYCLES);
   localparam bit         c_idle_en  = (IDLE_CYCLES != 0);

   // Three-bit encoding leaves spare codes; any of them falls back to RESET.
   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_IDLE  = 3'd1,
      ST_LANE0 = 3'd2,
      ST_LANE1 = 3'd3
   } state_t;

   state_t     r_state;
   logic       r_rel;        // first stage of the reset-release synchronizer
   logic [7:0] r_idle_cnt;

   logic       w_sync;
   logic       w_to_lane1;
   logic [7:0] w_cnt_inc;
   logic       w_expire;

   always_comb begin
      w_sync     = ALIGN_EN && (data_in_c == SYNC_BYTE);
      // Only a byte following a lane-0 byte goes to lane 1, and a sync byte
      // always overrides that.
      w_to_lane1 = (r_state == ST_LANE0) && !w_sync;
      // Saturating increment: the counter never wraps back to a small value.
      w_cnt_inc  = (r_idle_cnt == 8'hFF) ? r_idle_cnt : r_idle_cnt + 8'd1;
      w_expire   = c_idle_en && (w_cnt_inc >= c_idle_lim);
   end

   // Release synchronizer: r_rel is the first flop, the RESET state register
   // acts as the second, so the FSM leaves RESET on the 2nd edge after release.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         r_rel <= 1'b0;
      end else begin
         r_rel <= 1'b1;
      end
   end

   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_RESET;
         r_idle_cnt    <= 8'd0;
         data_out_0_c  <= 8'd0;
         valid_out_0_c <= 1'b0;
         data_out_1_c  <= 8'd0;
         valid_out_1_c <= 1'b0;
         realign_c     <= 1'b0;
      end else begin
         // Outputs last exactly one cycle unless a byte is accepted below.
         data_out_0_c  <= 8'd0;
         valid_out_0_c <= 1'b0;
         data_out_1_c  <= 8'd0;
         valid_out_1_c <= 1'b0;
         realign_c     <= 1'b0;

         case (r_state)
            ST_RESET: begin
               r_idle_cnt <= 8'd0;
               if (r_rel) begin
                  r_state <= ST_IDLE;
               end
            end

            ST_IDLE, ST_LANE0, ST_LANE1: begin
               if (valid_in_c) begin
                  // A valid byte always wins over a coincident timeout.
                  r_idle_cnt <= 8'd0;
                  realign_c  <= w_sync && (r_state == ST_LANE0);
                  if (w_to_lane1) begin
                     data_out_1_c  <= data_in_c;
                     valid_out_1_c <= 1'b1;
                     r_state       <= ST_LANE1;
                  end else begin
                     data_out_0_c  <= data_in_c;
                     valid_out_0_c <= 1'b1;
                     r_state       <= ST_LANE0;
                  end
               end else if (c_idle_en && (r_state != ST_IDLE)) begin
                  if (w_expire) begin
                     r_state    <= ST_IDLE;
                     r_idle_cnt <= 8'd0;
                  end else begin
                     r_idle_cnt <= w_cnt_inc;
                  end
               end
            end

            default: begin
               r_state    <= ST_RESET;
               r_idle_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_demux_1a2.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1a2
// Purpose  : Scoreboard bench for demux_1a2. Two instances share one input
//            stream: dut_a (ALIGN_EN=1, IDLE_CYCLES=0) and dut_b (ALIGN_EN=0,
//            IDLE_CYCLES=3). Expected lane/data/realign per accepted byte is
//            queued per instance at drive time and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1a2;

   typedef struct packed {
      logic       lane;
      logic [7:0] data;
      logic       rl;
   } exp_t;

   logic       clk_2f = 1'b0;
   logic       reset;
   logic [7:0] data_in_c;
   logic       valid_in_c;

   logic [7:0] da0, da1, db0, db1;
   logic       va0, va1, vb0, vb1, ra, rb;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;

   int total = 0;
   int bad   = 0;

   always #5 clk_2f = ~clk_2f;

   demux_1a2 #(.SYNC_BYTE(8'hBC), .ALIGN_EN(1'b1), .IDLE_CYCLES(0)) dut_a (
      .clk_2f(clk_2f), .reset(reset), .data_in_c(data_in_c), .valid_in_c(valid_in_c),
      .data_out_0_c(da0), .valid_out_0_c(va0), .data_out_1_c(da1),
      .valid_out_1_c(va1), .realign_c(ra));

   demux_1a2 #(.SYNC_BYTE(8'hBC), .ALIGN_EN(1'b0), .IDLE_CYCLES(3)) dut_b (
      .clk_2f(clk_2f), .reset(reset), .data_in_c(data_in_c), .valid_in_c(valid_in_c),
      .data_out_0_c(db0), .valid_out_0_c(vb0), .data_out_1_c(db1),
      .valid_out_1_c(vb1), .realign_c(rb));

   task automatic cmp(input string nm, input exp_t e, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input logic rl);
      logic       ev0, ev1;
      logic [7:0] ed0, ed1;
      ev0 = (e.lane == 1'b0);
      ev1 = (e.lane == 1'b1);
      ed0 = ev0 ? e.data : 8'd0;
      ed1 = ev1 ? e.data : 8'd0;
      total++;
      if (v0 !== ev0 || v1 !== ev1 || d0 !== ed0 || d1 !== ed1 || rl !== e.rl) begin
         bad++;
         $display("FAIL %s byte: got v0=%b d0=%h v1=%b d1=%h rl=%b, want v0=%b d0=%h v1=%b d1=%h rl=%b",
                  nm, v0, d0, v1, d1, rl, ev0, ed0, ev1, ed1, e.rl);
      end
   endtask

   task automatic idle_chk(input string nm, input logic [7:0] d0, input logic [7:0] d1);
      total++;
      if (d0 !== 8'd0 || d1 !== 8'd0) begin
         bad++;
         $display("FAIL %s idle data: got d0=%h d1=%h, want 00 00", nm, d0, d1);
      end
   endtask

   // Monitor: whenever an instance presents output, pop and compare.
   always @(negedge clk_2f) begin
      if (va0 === 1'b1 || va1 === 1'b1 || ra === 1'b1) begin
         if (q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL dut_a unexpected: got v0=%b d0=%h v1=%b d1=%h rl=%b, want no output",
                     va0, da0, va1, da1, ra);
         end else begin
            ea = q_a.pop_front();
            cmp("dut_a", ea, va0, da0, va1, da1, ra);
         end
      end else begin
         idle_chk("dut_a", da0, da1);
      end
      if (vb0 === 1'b1 || vb1 === 1'b1 || rb === 1'b1) begin
         if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL dut_b unexpected: got v0=%b d0=%h v1=%b d1=%h rl=%b, want no output",
                     vb0, db0, vb1, db1, rb);
         end else begin
            eb = q_b.pop_front();
            cmp("dut_b", eb, vb0, db0, vb1, db1, rb);
         end
      end else begin
         idle_chk("dut_b", db0, db1);
      end
   end

   task automatic chk_zero(input string tag);
      total++;
      if ({va0, va1, ra, da0, da1} !== 19'd0 || {vb0, vb1, rb, db0, db1} !== 19'd0) begin
         bad++;
         $display("FAIL %s zero: got a=%b%b%b %h %h b=%b%b%b %h %h, want all 0",
                  tag, va0, va1, ra, da0, da1, vb0, vb1, rb, db0, db1);
      end
   endtask

   // Drive one cycle; la/ra and lb/rb are the hand-computed lane and realign
   // expectations for dut_a and dut_b when the byte is valid.
   task automatic send(input logic v, input logic [7:0] d,
                       input logic la, input logic rla, input logic lb, input logic rlb);
      exp_t e;
      valid_in_c = v;
      data_in_c  = d;
      if (v) begin
         e.lane = la; e.data = d; e.rl = rla; q_a.push_back(e);
         e.lane = lb; e.data = d; e.rl = rlb; q_b.push_back(e);
      end
      @(posedge clk_2f);
      #1;
   endtask

   // Hold reset 3 edges, release between edges, bytes on the first two edges
   // after release must be ignored.
   task automatic release_seq();
      repeat (3) @(posedge clk_2f);
      #1;
      chk_zero("in_reset");
      reset      = 1'b1;
      valid_in_c = 1'b1;
      data_in_c  = 8'h11;
      @(posedge clk_2f); #1;
      chk_zero("rel_edge1");
      data_in_c  = 8'h22;
      @(posedge clk_2f); #1;
      chk_zero("rel_edge2");
      valid_in_c = 1'b0;
      data_in_c  = 8'h00;
   endtask

   task automatic do_reset();
      valid_in_c = 1'b0;
      @(negedge clk_2f);
      #1;
      reset = 1'b0;
      #1;
      chk_zero("async_clr");
      release_seq();
   endtask

   initial begin
      reset      = 1'b1;
      valid_in_c = 1'b0;
      data_in_c  = 8'h00;
      #2 reset = 1'b0;
      #1 chk_zero("por");
      release_seq();

      // Basic alternation
      send(1, 8'h01, 0, 0, 0, 0);
      send(1, 8'h02, 1, 0, 1, 0);
      send(1, 8'h03, 0, 0, 0, 0);
      send(1, 8'h04, 1, 0, 1, 0);
      // Gap of 2 keeps alternation on both (dut_b limit is 3)
      send(1, 8'hA0, 0, 0, 0, 0);
      send(0, 8'h00, 0, 0, 0, 0);
      send(0, 8'h00, 0, 0, 0, 0);
      send(1, 8'hA1, 1, 0, 1, 0);
      do_reset();

      // Gap of 3: dut_b times out back to lane 0
      send(1, 8'h10, 0, 0, 0, 0);
      repeat (3) send(0, 8'h00, 0, 0, 0, 0);
      send(1, 8'h20, 1, 0, 0, 0);
      do_reset();

      // Gap of 2: no timeout
      send(1, 8'h10, 0, 0, 0, 0);
      repeat (2) send(0, 8'h00, 0, 0, 0, 0);
      send(1, 8'h20, 1, 0, 1, 0);
      do_reset();

      // Sync realignment (dut_b treats BC as data)
      send(1, 8'h55, 0, 0, 0, 0);
      send(1, 8'hBC, 0, 1, 1, 0);
      send(1, 8'h66, 1, 0, 0, 0);
      send(1, 8'hBC, 0, 0, 1, 0);
      send(1, 8'hBC, 0, 1, 0, 0);
      send(1, 8'hBC, 0, 1, 1, 0);
      do_reset();

      // Sync as first byte: no realign pulse
      send(1, 8'hBC, 0, 0, 0, 0);
      send(1, 8'h01, 1, 0, 1, 0);
      send(1, 8'h33, 0, 0, 0, 0);

      // Mid-stream async reset while lane 1 is valid
      valid_in_c = 1'b1;
      data_in_c  = 8'h44;
      @(posedge clk_2f); #1;
      total++;
      if (va1 !== 1'b1 || da1 !== 8'h44 || vb1 !== 1'b1 || db1 !== 8'h44) begin
         bad++;
         $display("FAIL pre_reset lane1: got a=%b/%h b=%b/%h, want 1/44", va1, da1, vb1, db1);
      end
      valid_in_c = 1'b0;
      data_in_c  = 8'h00;
      #1 reset = 1'b0;
      #1 chk_zero("midstream_async");
      release_seq();
      send(1, 8'h77, 0, 0, 0, 0);
      repeat (3) send(0, 8'h00, 0, 0, 0, 0);

      total++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         bad++;
         $display("FAIL drain: got pending a=%0d b=%0d, want 0 0", q_a.size(), q_b.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
